// File: rtl/input_conditioner.sv
// input_conditioner
// Turns the raw SoCKit push-buttons and slide switches into clean control
// signals for the LED blinker. Every raw bit goes through a two-flop
// synchronizer and a counter-based debouncer. The two keys then get
// press-edge detection, so one press gives one single-cycle pulse. The four
// switches become a stable delay value.
//
// Channel map (index into the 6-bit channel vectors):
//   0 : key_n[0] -> btn_reset pulse
//   1 : key_n[1] -> btn_pause pulse
//   2..5 : sw[0..3] -> delay[0..3]

module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,  // stable cycles needed to accept a level, >= 2
   parameter int CNT_WIDTH       = 20       // 2**CNT_WIDTH must exceed DEBOUNCE_CYCLES
) (
   input  logic       clk,
   input  logic       reset,      // synchronous, active high
   input  logic [1:0] key_n,      // raw active-low push-buttons, asynchronous
   input  logic [3:0] sw,         // raw slide switches, asynchronous
   output logic       btn_reset,  // one-cycle pulse per debounced press of key_n[0]
   output logic       btn_pause,  // one-cycle pulse per debounced press of key_n[1]
   output logic [3:0] delay       // debounced switch levels
);

   localparam int NCH = 6;

   // Keys idle high (released), switches idle low.
   localparam logic [NCH-1:0] IDLE_LEVEL = 6'b00_0011;

   // Terminal count: the N-th consecutive disagreeing edge is the accept edge.
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [NCH-1:0]       raw;
   logic [NCH-1:0]       s1_q;
   logic [NCH-1:0]       s2_q;
   logic [NCH-1:0]       stable_q;
   logic [NCH-1:0]       stable_d;
   logic [NCH-1:0]       accept;
   logic [CNT_WIDTH-1:0] cnt_q [NCH];
   logic [CNT_WIDTH-1:0] cnt_d [NCH];
   logic [1:0]           btn_q;
   logic [1:0]           btn_d;

   assign raw = {sw, key_n};

   // Two-flop synchronizer for every raw input; only s2 is used downstream.
   always_ff @(posedge clk) begin
      // NOTE: reset here is sampled on the clock edge like any other input,
      // so it belongs inside the clocked branch rather than the sensitivity list.
      if (reset) begin
         s1_q <= IDLE_LEVEL;
         s2_q <= IDLE_LEVEL;
      end else begin
         // NOTE: non-blocking so s2 takes the old s1, giving two real stages.
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   // Debounce rule per channel: agreement clears the count, N consecutive
   // disagreeing edges accept the new level, and the count never wraps.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch can be inferred.
      stable_d = stable_q;
      accept   = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         cnt_d[ch] = cnt_q[ch];
         if (s2_q[ch] == stable_q[ch]) begin
            cnt_d[ch] = '0;
         end else if (cnt_q[ch] == CNT_MAX) begin
            stable_d[ch] = s2_q[ch];
            accept[ch]   = 1'b1;
            cnt_d[ch]    = '0;
         end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_WIDTH'(1);
         end
      end
      // A press is an accept edge on a key channel whose new level is low.
      btn_d = accept[1:0] & ~s2_q[1:0];
   end

   // Accepted levels, debounce counters and registered key pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= IDLE_LEVEL;
         btn_q    <= '0;
         // NOTE: the counters are a small register array, not a RAM, so they
         // are cleared here to drop any partial count across reset.
         for (int ch = 0; ch < NCH; ch++) begin
            cnt_q[ch] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         btn_q    <= btn_d;
         for (int ch = 0; ch < NCH; ch++) begin
            cnt_q[ch] <= cnt_d[ch];
         end
      end
   end

   assign btn_reset = btn_q[0];
   assign btn_pause = btn_q[1];
   assign delay     = stable_q[5:2];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the next rising edge, so each step covers exactly one edge.

module tb_input_conditioner;

   localparam int DEB = 4;
   localparam int CW  = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] key_n;
   logic [3:0] sw;
   logic       btn_reset;
   logic       btn_pause;
   logic [3:0] delay;

   int n_vec = 0;
   int n_err = 0;
   int n_edge = 0;

   input_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .CNT_WIDTH       (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .key_n     (key_n),
      .sw        (sw),
      .btn_reset (btn_reset),
      .btn_pause (btn_pause),
      .delay     (delay)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic [1:0] key_n;
      logic [3:0] sw;
      logic [7:0] cycles;
      logic       br;
      logic       bp;
      logic [3:0] dly;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   // Drive one set of inputs across one rising edge and compare the outputs.
   task automatic step(input logic r, input logic [1:0] k, input logic [3:0] s,
                       input logic ebr, input logic ebp, input logic [3:0] edly,
                       input string tag);
      reset = r;
      key_n = k;
      sw    = s;
      @(posedge clk);
      #1;
      n_edge++;
      n_vec++;
      if ({btn_reset, btn_pause, delay} !== {ebr, ebp, edly}) begin
         n_err++;
         $display("FAIL %s edge %0d: got btn_reset=%b btn_pause=%b delay=%b, want btn_reset=%b btn_pause=%b delay=%b",
                  tag, n_edge, btn_reset, btn_pause, delay, ebr, ebp, edly);
      end
   endtask

   initial begin
      reset = 1'b1;
      key_n = 2'b11;
      sw    = 4'b0000;

      //            rst   key_n  sw       cyc  br    bp    delay
      // reset, then idle
      vecs[0]  = '{1'b1, 2'b11, 4'b0000, 8'd3,  1'b0, 1'b0, 4'b0000};
      vecs[1]  = '{1'b0, 2'b11, 4'b0000, 8'd4,  1'b0, 1'b0, 4'b0000};
      // clean press of key_n[1], held 20 cycles, then release
      vecs[2]  = '{1'b0, 2'b01, 4'b0000, 8'd5,  1'b0, 1'b0, 4'b0000};
      vecs[3]  = '{1'b0, 2'b01, 4'b0000, 8'd1,  1'b0, 1'b1, 4'b0000};
      vecs[4]  = '{1'b0, 2'b01, 4'b0000, 8'd14, 1'b0, 1'b0, 4'b0000};
      vecs[5]  = '{1'b0, 2'b11, 4'b0000, 8'd8,  1'b0, 1'b0, 4'b0000};
      // 3-cycle glitch on sw[2] is rejected
      vecs[6]  = '{1'b0, 2'b11, 4'b0100, 8'd3,  1'b0, 1'b0, 4'b0000};
      vecs[7]  = '{1'b0, 2'b11, 4'b0000, 8'd8,  1'b0, 1'b0, 4'b0000};
      // switches 0000 -> 1010 -> 0000, both bits on the same edge
      vecs[8]  = '{1'b0, 2'b11, 4'b1010, 8'd5,  1'b0, 1'b0, 4'b0000};
      vecs[9]  = '{1'b0, 2'b11, 4'b1010, 8'd1,  1'b0, 1'b0, 4'b1010};
      vecs[10] = '{1'b0, 2'b11, 4'b1010, 8'd6,  1'b0, 1'b0, 4'b1010};
      vecs[11] = '{1'b0, 2'b11, 4'b0000, 8'd5,  1'b0, 1'b0, 4'b1010};
      vecs[12] = '{1'b0, 2'b11, 4'b0000, 8'd3,  1'b0, 1'b0, 4'b0000};
      // dual press: both keys pulse together at E5, release gives nothing
      vecs[13] = '{1'b0, 2'b00, 4'b0000, 8'd5,  1'b0, 1'b0, 4'b0000};
      vecs[14] = '{1'b0, 2'b00, 4'b0000, 8'd1,  1'b1, 1'b1, 4'b0000};
      vecs[15] = '{1'b0, 2'b00, 4'b0000, 8'd6,  1'b0, 1'b0, 4'b0000};
      vecs[16] = '{1'b0, 2'b11, 4'b0000, 8'd8,  1'b0, 1'b0, 4'b0000};

      for (int v = 0; v < NVEC; v++) begin
         for (int c = 0; c < int'(vecs[v].cycles); c++) begin
            step(vecs[v].rst, vecs[v].key_n, vecs[v].sw,
                 vecs[v].br, vecs[v].bp, vecs[v].dly, $sformatf("vec%0d", v));
         end
      end

      // Bounce on key_n[0]: low 3, high 1, then low 20. The first low run
      // never reaches the accept edge; the pulse lands at E5 of the final fall.
      for (int c = 0; c < 3; c++) step(1'b0, 2'b10, 4'b0000, 1'b0, 1'b0, 4'b0000, "bounce_low1");
      step(1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'b0000, "bounce_high");
      for (int c = 0; c < 5; c++) step(1'b0, 2'b10, 4'b0000, 1'b0, 1'b0, 4'b0000, "bounce_wait");
      step(1'b0, 2'b10, 4'b0000, 1'b1, 1'b0, 4'b0000, "bounce_pulse");
      for (int c = 0; c < 14; c++) step(1'b0, 2'b10, 4'b0000, 1'b0, 1'b0, 4'b0000, "bounce_hold");
      for (int c = 0; c < 8; c++) step(1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'b0000, "bounce_release");

      // Set delay to 1111 so the reset test can see it cleared.
      for (int c = 0; c < 5; c++) step(1'b0, 2'b11, 4'b1111, 1'b0, 1'b0, 4'b0000, "sw_all_wait");
      for (int c = 0; c < 3; c++) step(1'b0, 2'b11, 4'b1111, 1'b0, 1'b0, 4'b1111, "sw_all_set");

      // Reset mid-count: key_n[1] falls at E0, reset sampled at E2, key held.
      // Both the key and the still-high switches restart from the first
      // post-reset edge R0 and are accepted at R5.
      step(1'b0, 2'b01, 4'b1111, 1'b0, 1'b0, 4'b1111, "rst_mid_e0");
      step(1'b0, 2'b01, 4'b1111, 1'b0, 1'b0, 4'b1111, "rst_mid_e1");
      step(1'b1, 2'b01, 4'b1111, 1'b0, 1'b0, 4'b0000, "rst_mid_reset");
      for (int c = 0; c < 5; c++) step(1'b0, 2'b01, 4'b1111, 1'b0, 1'b0, 4'b0000, "rst_mid_wait");
      step(1'b0, 2'b01, 4'b1111, 1'b0, 1'b1, 4'b1111, "rst_mid_pulse");
      for (int c = 0; c < 6; c++) step(1'b0, 2'b01, 4'b1111, 1'b0, 1'b0, 4'b1111, "rst_mid_hold");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
